// File: rtl/mvm_pkg.sv
// Shared types for the mvm_stream matrix-vector engine: controller states and
// the per-stage tag that travels alongside datapath values.
package mvm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } stage_tag_t;

endpackage

// File: rtl/mvm_stream_lane.sv
// One output lane of mvm_stream: elementwise signed multiply, adder tree, and row accumulator.
// Defining MVM_STREAM_RELU_EN clamps negative lane results to zero at the output register.
module mvm_stream_lane
    import mvm_pkg::*;
#(
    parameter int IWIDTH    = 8,
    parameter int OWIDTH    = 32,
    parameter int VEC_LANES = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        advance,
    input  logic [IWIDTH*VEC_LANES-1:0] vec_word,
    input  logic [IWIDTH*VEC_LANES-1:0] mat_word,
    input  stage_tag_t                  acc_tag,
    output logic [OWIDTH-1:0]           result
);

    localparam int PWIDTH = 2 * IWIDTH;

    logic signed [PWIDTH-1:0] prod [VEC_LANES];
    logic [OWIDTH-1:0] tree_sum;
    logic [OWIDTH-1:0] tree_q;
    logic [OWIDTH-1:0] acc_q;
    logic [OWIDTH-1:0] acc_next;
    logic [OWIDTH-1:0] out_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < VEC_LANES; i++) prod[i] <= '0;
        end else if (advance) begin
            for (int unsigned i = 0; i < VEC_LANES; i++)
                prod[i] <= PWIDTH'($signed(vec_word[i*IWIDTH +: IWIDTH]))
                         * PWIDTH'($signed(mat_word[i*IWIDTH +: IWIDTH]));
        end
    end

    // Products are sign-extended before summing; the sum wraps at OWIDTH bits.
    always_comb begin
        tree_sum = '0;
        for (int unsigned i = 0; i < VEC_LANES; i++)
            tree_sum = tree_sum + OWIDTH'(prod[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          tree_q <= '0;
        else if (advance) tree_q <= tree_sum;
    end

    always_comb begin
        acc_next = acc_tag.first ? tree_q : acc_q + tree_q;
`ifdef MVM_STREAM_RELU_EN
        out_val = acc_next[OWIDTH-1] ? '0 : acc_next;
`else
        out_val = acc_next;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            result <= '0;
        end else if (advance && acc_tag.valid) begin
            acc_q <= acc_next;
            if (acc_tag.last) result <= out_val;
        end
    end

endmodule

// File: rtl/mvm_stream.sv
// Streaming matrix-vector multiplier: one vector memory, one matrix memory per output lane,
// four-stage stalling pipeline with valid/ready output. MVM_STREAM_RELU_EN enables ReLU output.
module mvm_stream
    import mvm_pkg::*;
#(
    parameter int IWIDTH        = 8,
    parameter int OWIDTH        = 32,
    parameter int VEC_LANES     = 8,
    parameter int VEC_MEM_DEPTH = 256,
    parameter int MAT_MEM_DEPTH = 512,
    parameter int NUM_OLANES    = 8,
    localparam int MEM_DATAW    = IWIDTH * VEC_LANES,
    localparam int VEC_ADDRW    = $clog2(VEC_MEM_DEPTH),
    localparam int MAT_ADDRW    = $clog2(MAT_MEM_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [MEM_DATAW-1:0]         i_vec_wdata,
    input  logic [VEC_ADDRW-1:0]         i_vec_waddr,
    input  logic                         i_vec_wen,
    input  logic [MEM_DATAW-1:0]         i_mat_wdata,
    input  logic [MAT_ADDRW-1:0]         i_mat_waddr,
    input  logic [NUM_OLANES-1:0]        i_mat_wen,
    input  logic                         i_start,
    input  logic [VEC_ADDRW-1:0]         i_vec_start_addr,
    input  logic [VEC_ADDRW:0]           i_vec_num_words,
    input  logic [MAT_ADDRW-1:0]         i_mat_start_addr,
    input  logic [MAT_ADDRW:0]           i_mat_num_rows_per_olane,
    output logic [NUM_OLANES*OWIDTH-1:0] o_result,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic                         o_busy
);

    state_t state, next_state;

    logic                 advance, issue, accept;
    logic                 last_word, last_row;
    logic [VEC_ADDRW:0]   job_words, word_cnt;
    logic [MAT_ADDRW:0]   job_rows, row_cnt;
    logic [VEC_ADDRW-1:0] job_vec_start, vec_addr;
    logic [MAT_ADDRW-1:0] mat_addr;
    stage_tag_t           issue_tag, s1_tag, s2_tag, s3_tag;

    logic [MEM_DATAW-1:0] vec_mem [VEC_MEM_DEPTH];
    logic [MEM_DATAW-1:0] vec_rd;

    assign advance   = !(o_valid && !i_ready);
    assign last_word = (word_cnt == job_words - (VEC_ADDRW+1)'(1));
    assign last_row  = (row_cnt == job_rows - (MAT_ADDRW+1)'(1));
    assign issue_tag = '{valid: issue, first: issue && (word_cnt == '0), last: issue && last_word};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:  if (accept) next_state = ST_RUN;
            ST_RUN:   if (issue && last_word && last_row) next_state = ST_DRAIN;
            // Only the final beat can be on the output once the pipeline behind it is empty.
            ST_DRAIN: if (o_valid && i_ready && !(s1_tag.valid || s2_tag.valid || s3_tag.valid))
                          next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state != ST_IDLE);
        issue  = (state == ST_RUN) && advance;
        accept = (state == ST_IDLE) && i_start
              && (i_vec_num_words != '0) && (i_mat_num_rows_per_olane != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job_words     <= '0;
            job_rows      <= '0;
            job_vec_start <= '0;
            vec_addr      <= '0;
            mat_addr      <= '0;
            word_cnt      <= '0;
            row_cnt       <= '0;
        end else if (accept) begin
            job_words     <= i_vec_num_words;
            job_rows      <= i_mat_num_rows_per_olane;
            job_vec_start <= i_vec_start_addr;
            vec_addr      <= i_vec_start_addr;
            mat_addr      <= i_mat_start_addr;
            word_cnt      <= '0;
            row_cnt       <= '0;
        end else if (issue) begin
            mat_addr <= (mat_addr == MAT_ADDRW'(MAT_MEM_DEPTH - 1)) ? '0 : mat_addr + MAT_ADDRW'(1);
            if (last_word) begin
                word_cnt <= '0;
                vec_addr <= job_vec_start;
                row_cnt  <= row_cnt + (MAT_ADDRW+1)'(1);
            end else begin
                word_cnt <= word_cnt + (VEC_ADDRW+1)'(1);
                vec_addr <= (vec_addr == VEC_ADDRW'(VEC_MEM_DEPTH - 1)) ? '0 : vec_addr + VEC_ADDRW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_vec_wen) vec_mem[i_vec_waddr] <= i_vec_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_rd  <= '0;
            s1_tag  <= '0;
            s2_tag  <= '0;
            s3_tag  <= '0;
            o_valid <= 1'b0;
        end else if (advance) begin
            vec_rd  <= vec_mem[vec_addr];
            s1_tag  <= issue_tag;
            s2_tag  <= s1_tag;
            s3_tag  <= s2_tag;
            o_valid <= s3_tag.valid && s3_tag.last;
        end
    end

    for (genvar k = 0; k < NUM_OLANES; k++) begin : g_lane
        logic [MEM_DATAW-1:0] mat_mem [MAT_MEM_DEPTH];
        logic [MEM_DATAW-1:0] mat_rd;

        always_ff @(posedge clk) begin
            if (i_mat_wen[k]) mat_mem[i_mat_waddr] <= i_mat_wdata;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst)          mat_rd <= '0;
            else if (advance) mat_rd <= mat_mem[mat_addr];
        end

        mvm_stream_lane #(
            .IWIDTH    (IWIDTH),
            .OWIDTH    (OWIDTH),
            .VEC_LANES (VEC_LANES)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .advance  (advance),
            .vec_word (vec_rd),
            .mat_word (mat_rd),
            .acc_tag  (s3_tag),
            .result   (o_result[k*OWIDTH +: OWIDTH])
        );
    end

endmodule

// File: tb/tb_mvm_stream.sv
// Self-checking bench for mvm_stream: memory-mirroring dot-product model, per-cycle output compare.
// Build with MVM_STREAM_RELU_EN defined to check the ReLU variant.
module tb_mvm_stream;

    localparam int IW = 8;
    localparam int OW = 32;
    localparam int VL = 8;
    localparam int VD = 256;
    localparam int MD = 512;
    localparam int NO = 8;
    localparam int DW = IW * VL;
    localparam int VAW = 8;
    localparam int MAW = 9;
    localparam int RW = NO * OW;

    logic           clk = 1'b0;
    logic           rst;
    logic [DW-1:0]  i_vec_wdata, i_mat_wdata;
    logic [VAW-1:0] i_vec_waddr, i_vec_start_addr;
    logic           i_vec_wen;
    logic [MAW-1:0] i_mat_waddr, i_mat_start_addr;
    logic [NO-1:0]  i_mat_wen;
    logic           i_start;
    logic [VAW:0]   i_vec_num_words;
    logic [MAW:0]   i_mat_num_rows_per_olane;
    logic [RW-1:0]  o_result;
    logic           o_valid, o_busy;
    logic           i_ready = 1'b1;

    always #5 clk = ~clk;

    mvm_stream #(
        .IWIDTH(IW), .OWIDTH(OW), .VEC_LANES(VL),
        .VEC_MEM_DEPTH(VD), .MAT_MEM_DEPTH(MD), .NUM_OLANES(NO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_vec_wdata(i_vec_wdata), .i_vec_waddr(i_vec_waddr), .i_vec_wen(i_vec_wen),
        .i_mat_wdata(i_mat_wdata), .i_mat_waddr(i_mat_waddr), .i_mat_wen(i_mat_wen),
        .i_start(i_start), .i_vec_start_addr(i_vec_start_addr), .i_vec_num_words(i_vec_num_words),
        .i_mat_start_addr(i_mat_start_addr), .i_mat_num_rows_per_olane(i_mat_num_rows_per_olane),
        .o_result(o_result), .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy)
    );

    logic [DW-1:0] m_vec [VD];
    logic [DW-1:0] m_mat [NO][MD];
    logic [RW-1:0] exp_q [$];
    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;
    bit rdy_rand = 1'b0;
    bit rdy_manual = 1'b1;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Each lane's result for row r is a plain dot product over W words, wrapped to 32 bits.
    function automatic logic [RW-1:0] model_beat(input int vs, input int w_n, input int ms, input int r);
        logic [RW-1:0] beat;
        logic [DW-1:0] vw, mw;
        int acc;
        beat = '0;
        for (int k = 0; k < NO; k++) begin
            acc = 0;
            for (int w = 0; w < w_n; w++) begin
                vw = m_vec[(vs + w) % VD];
                mw = m_mat[k][(ms + r * w_n + w) % MD];
                for (int e = 0; e < VL; e++)
                    acc += int'($signed(vw[e*IW +: IW])) * int'($signed(mw[e*IW +: IW]));
            end
`ifdef MVM_STREAM_RELU_EN
            if (acc < 0) acc = 0;
`endif
            beat[k*OW +: OW] = acc;
        end
        return beat;
    endfunction

    always @(posedge clk) begin
        #2;
        i_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_manual;
    end

    logic [RW-1:0] prev_res;
    bit prev_stall = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", RW'(o_valid), RW'(1));
                chk("stall_hold", o_result, prev_res);
            end
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got %h required no beat", o_result);
                end else if (i_ready) begin
                    chk("beat", o_result, exp_q.pop_front());
                    n_acc++;
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_res = o_result;
        end
    end

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic wv(input int a, input logic [DW-1:0] d);
        i_vec_waddr = VAW'(a);
        i_vec_wdata = d;
        i_vec_wen = 1'b1;
        m_vec[a] = d;
        @(posedge clk);
        #1 i_vec_wen = 1'b0;
    endtask

    task automatic wm(input logic [NO-1:0] mask, input int a, input logic [DW-1:0] d);
        i_mat_waddr = MAW'(a);
        i_mat_wdata = d;
        i_mat_wen = mask;
        for (int k = 0; k < NO; k++) if (mask[k]) m_mat[k][a] = d;
        @(posedge clk);
        #1 i_mat_wen = '0;
    endtask

    task automatic fill_random(input int vs, input int w_n, input int ms, input int r_n);
        for (int w = 0; w < w_n; w++) wv((vs + w) % VD, rnd64());
        for (int k = 0; k < NO; k++)
            for (int i = 0; i < r_n * w_n; i++) wm(NO'(1) << k, (ms + i) % MD, rnd64());
    endtask

    task automatic push_job(input int vs, input int w_n, input int ms, input int r_n);
        for (int r = 0; r < r_n; r++) exp_q.push_back(model_beat(vs, w_n, ms, r));
    endtask

    task automatic start_job(input int vs, input int w_n, input int ms, input int r_n);
        i_vec_start_addr = VAW'(vs);
        i_vec_num_words = (VAW+1)'(w_n);
        i_mat_start_addr = MAW'(ms);
        i_mat_num_rows_per_olane = (MAW+1)'(r_n);
        i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!o_busy) break;
        end
        if (i >= budget) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: busy after %0d cycles, required idle", name, budget);
        end
        chk({name, "_left"}, RW'(exp_q.size()), RW'(0));
    endtask

    task automatic wait_valid(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_valid) break;
        end
        if (i >= budget) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: no o_valid in %0d cycles, required 1", name, budget);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] pin;
        int base, i, vs, ms, wn, rn;

        rst = 1'b1;
        i_vec_wen = 1'b0; i_mat_wen = '0; i_start = 1'b0;
        i_vec_wdata = '0; i_mat_wdata = '0; i_vec_waddr = '0; i_mat_waddr = '0;
        i_vec_start_addr = '0; i_vec_num_words = '0; i_mat_start_addr = '0; i_mat_num_rows_per_olane = '0;
        #23;
        chk("rst_valid", RW'(o_valid), RW'(0));
        chk("rst_busy", RW'(o_busy), RW'(0));
        chk("rst_result", o_result, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // All ones, one word, one row: each lane 8, o_valid at the 5th edge from start.
        wv(0, {8{8'h01}});
        wm('1, 0, {8{8'h01}});
        push_job(0, 1, 0, 1);
        pin = exp_q[0];
        chk("model_ones", pin, {NO{32'd8}});
        start_job(0, 1, 0, 1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 4) chk("lat_c4", RW'(o_valid), RW'(0));
            if (c == 5) begin
                chk("lat_c5", RW'(o_valid), RW'(1));
                chk("lane0_ones", RW'(o_result[31:0]), RW'(8));
            end
        end
        wait_idle(50, "ones");

        // Random W=4 R=3; busy must drop right after the third accept.
        vs = $urandom_range(0, VD - 1); ms = $urandom_range(0, MD - 1);
        fill_random(vs, 4, ms, 3);
        push_job(vs, 4, ms, 3);
        base = n_acc;
        start_job(vs, 4, ms, 3);
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (n_acc == base + 3) break;
        end
        chk("busy_at_last", RW'(o_busy), RW'(1));
        @(negedge clk);
        chk("busy_after_last", RW'(o_busy), RW'(0));
        wait_idle(50, "w4r3");

        // Hold off the first beat of four for ten cycles.
        vs = $urandom_range(0, VD - 1); ms = $urandom_range(0, MD - 1);
        fill_random(vs, 2, ms, 4);
        push_job(vs, 2, ms, 4);
        rdy_manual = 1'b0;
        start_job(vs, 2, ms, 4);
        wait_valid(100, "stall");
        repeat (10) @(negedge clk);
        rdy_manual = 1'b1;
        wait_idle(200, "stall");

        // Extreme elements across the whole vector memory.
        for (int a = 0; a < VD; a++) begin
            wv(a, {8{8'h80}});
            wm('1, a, {8{8'h80}});
        end
        push_job(0, VD, 0, 1);
        pin = exp_q[0];
        chk("model_extreme", pin, {NO{32'h0200_0000}});
        start_job(0, VD, 0, 1);
        wait_idle(2000, "extreme");

        // Matrix address wrap, plus an ignored start while busy.
        vs = $urandom_range(0, VD - 2); ms = 510;
        fill_random(vs, 2, ms, 2);
        wv(vs, {8{8'h01}}); wv(vs + 1, {8{8'h01}});
        wm(NO'(1), 510, {8{8'h01}}); wm(NO'(1), 511, {8{8'h02}});
        wm(NO'(1), 0, {8{8'h03}});   wm(NO'(1), 1, {8{8'h04}});
        push_job(vs, 2, ms, 2);
        pin = exp_q[0];
        chk("model_wrap_r0", RW'(pin[31:0]), RW'(24));
        pin = exp_q[1];
        chk("model_wrap_r1", RW'(pin[31:0]), RW'(56));
        start_job(vs, 2, ms, 2);
        @(negedge clk);
        @(negedge clk);
        start_job(0, 1, 0, 1);
        chk("busy_ignored", RW'(o_busy), RW'(1));
        wait_idle(100, "wrap");

        // Randomized jobs under random backpressure.
        rdy_rand = 1'b1;
        for (int j = 0; j < 4; j++) begin
            vs = $urandom_range(0, VD - 1); ms = $urandom_range(0, MD - 1);
            wn = $urandom_range(1, 6); rn = $urandom_range(1, 4);
            fill_random(vs, wn, ms, rn);
            push_job(vs, wn, ms, rn);
            start_job(vs, wn, ms, rn);
            wait_idle(400, "rand");
        end
        rdy_rand = 1'b0;
        @(negedge clk);

        // Asynchronous reset while a beat is stalled mid-run.
        fill_random(5, 2, 100, 4);
        push_job(5, 2, 100, 4);
        rdy_manual = 1'b0;
        start_job(5, 2, 100, 4);
        wait_valid(100, "midrun");
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", RW'(o_valid), RW'(0));
        chk("arst_busy", RW'(o_busy), RW'(0));
        chk("arst_result", o_result, '0);
        exp_q.delete();
        rdy_manual = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_rst_idle", RW'(o_valid), RW'(0));
        fill_random(3, 1, 40, 1);
        push_job(3, 1, 40, 1);
        start_job(3, 1, 40, 1);
        wait_idle(50, "after_rst");

        // Negative dot product: -8 raw, 0 with ReLU.
        wv(10, {8{8'h01}});
        wm('1, 20, {8{8'hFF}});
        push_job(10, 1, 20, 1);
        pin = exp_q[0];
`ifdef MVM_STREAM_RELU_EN
        chk("model_neg", pin, '0);
`else
        chk("model_neg", pin, {NO{32'hFFFF_FFF8}});
`endif
        start_job(10, 1, 20, 1);
        wait_idle(50, "neg");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
